stage_wb_buffered: RTL and testbench
====================================

# stage_wb_buffered

Parametrised writeback stage for the pipelined core. It selects the final result from four sources, with optional narrow-load extension. The result goes into a two-entry buffer, so a busy register-file write port stalls writeback without losing instructions. Also exposes buffered destinations for hazard forwarding and keeps a retired-instruction counter.

## Interface
- DATA_W, 8: datapath width; must be even, ≥4
- ADDR_W, 3: register address width
- CNT_W, 16: retire counter width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard the input beat presented this cycle
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat
- in_regwrite  in  1  beat writes a register
- in_result_src  in  2  0 ALU, 1 memory, 2 link, 3 immediate
- in_alu, in_mem, in_link, in_imm  in  DATA_W each  candidate results
- in_load_narrow  in  1  memory result is a half-width load
- in_load_sx  in  1  sign-extend narrow load (else zero-extend)
- in_rd  in  ADDR_W  destination register
- wr_en  out  1  register-file write request (head entry valid)
- wr_addr  out  ADDR_W  head destination
- wr_data  out  DATA_W  head data
- wr_ready  in  1  register file accepts write this cycle
- fwd0_valid/fwd0_addr/fwd0_data  out  1/ADDR_W/DATA_W  head entry (older)
- fwd1_valid/fwd1_addr/fwd1_data  out  1/ADDR_W/DATA_W  skid entry (younger)
- retire_count  out  CNT_W  retired-instruction count

## Operation
- Accept = in_valid & in_ready & ~flush. A flushed beat is neither stored nor counted.
- in_ready = (occupancy < 2). It depends on registered state only, with no combinational path from wr_ready or in_valid.
- Result mux at accept time:
  - src 0 selects in_alu, 2 selects in_link, 3 selects in_imm.
  - src 1 with in_load_narrow=0 selects in_mem.
  - src 1 with in_load_narrow=1 takes in_mem[DATA_W/2-1:0]. It is sign-extended if in_load_sx=1, else zero-extended.
- Beats with in_regwrite=0 are accepted and counted but never enqueued.
- Buffer: head and skid registers, each holding valid, addr and data. Occupancy is 0, 1 or 2.
  - A write completes when wr_en & wr_ready.
  - Occupancy 0: an accepted regwrite beat loads the head.
  - Occupancy 1, no completion: the beat loads the skid.
  - Occupancy 1, with completion: the beat loads the head (replacing it).
  - Occupancy 2, with completion: skid moves to head and the skid empties (in_ready is 0, so no accept).
- Writes leave in acceptance order. There is no merging, even for the same address.
- Forwarding consumers prefer fwd1 over fwd0 when addresses match; the younger entry wins.
- flush never affects buffered entries; they are committed.
- retire_count += 1 per accepted beat and wraps modulo 2^CNT_W.
- in_link and in_imm are used verbatim; no extension is applied.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, all fwd*=0, retire_count=0, in_ready=1 (the cycle after reset deasserts). Reset asserted mid-operation drops both entries, with no partial write.
- Latency: a beat accepted at edge N presents wr_en=1 in the cycle after edge N. Its write completes at the first later edge where wr_ready=1.
- Throughput: one write per cycle while wr_ready stays 1. in_ready falls only after two consecutive stalled accepts.
- Outputs hold stable while wr_en=1 & wr_ready=0.
- retire_count updates at the accept edge, visible the next cycle.

## Test plan
- Back-to-back ALU beats (rd=1 data 0x11, rd=2 data 0x22), wr_ready=1 -> writes (1,0x11) then (2,0x22) on consecutive cycles; retire_count=2.
- Narrow load with in_mem=0x3C, the sign bit of its low half set:
  - sx=1 -> 0xFC.
  - sx=0 -> 0x0C.
  - Full load of in_mem=0x8A -> 0x8A.
- Hold wr_ready=0 and present 3 beats:
  - The first two are accepted and fwd0/fwd1 show them; in_ready=0 and the third is held.
  - Release wr_ready -> three writes in order, with no loss or duplication.
- flush with in_valid=1 while the head is pending -> the flushed beat is never written and retire_count is unchanged; the head still writes.
- in_regwrite=0 beat between two writes -> no wr_en for it; retire_count counts all 3.
- Reset asserted with occupancy 2 -> next cycle wr_en=0, fwd*_valid=0, retire_count=0; the CNT_W=4 wrap test counts 15 -> 0.

Source files
------------

// File: rtl/stage_wb_buffered.sv
// Writeback stage: selects the final result, extends narrow loads, and queues
// register-file writes in a two-entry head/skid buffer with a retire counter.
module stage_wb_buffered #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic [1:0]        in_result_src,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_link,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_load_narrow,
    input  logic              in_load_sx,
    input  logic [ADDR_W-1:0] in_rd,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              fwd0_valid,
    output logic [ADDR_W-1:0] fwd0_addr,
    output logic [DATA_W-1:0] fwd0_data,
    output logic              fwd1_valid,
    output logic [ADDR_W-1:0] fwd1_addr,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    occ_e              occ_q, occ_d;
    logic              accept, enq, done;
    logic              load_head, load_skid, shift_skid;
    logic [DATA_W-1:0] mem_val, result;
    logic [ADDR_W-1:0] head_addr, skid_addr;
    logic [DATA_W-1:0] head_data, skid_data;
    logic [CNT_W-1:0]  count_q;

    // Handshake terms; in_ready depends on registered occupancy only.
    assign in_ready = (occ_q != OCC_TWO);
    assign wr_en    = (occ_q != OCC_EMPTY);
    assign done     = wr_en & wr_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign enq      = accept & in_regwrite;

    assign wr_addr      = head_addr;
    assign wr_data      = head_data;
    assign fwd0_valid   = wr_en;
    assign fwd0_addr    = head_addr;
    assign fwd0_data    = head_data;
    assign fwd1_valid   = (occ_q == OCC_TWO);
    assign fwd1_addr    = skid_addr;
    assign fwd1_data    = skid_data;
    assign retire_count = count_q;

    // Result source selection with optional half-width load extension.
    always_comb begin
        mem_val = in_mem;
        if (in_load_narrow) begin
            mem_val = {{HALF{in_load_sx & in_mem[HALF-1]}}, in_mem[HALF-1:0]};
        end
        unique case (in_result_src)
            2'd0:    result = in_alu;
            2'd1:    result = mem_val;
            2'd2:    result = in_link;
            default: result = in_imm;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Next occupancy and buffer load/shift controls.
    always_comb begin
        occ_d      = occ_q;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (enq) begin
                    load_head = 1'b1;
                    occ_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (done) begin
                    // Head retires this edge, so a new beat goes straight into head.
                    if (enq) begin
                        load_head = 1'b1;
                    end else begin
                        occ_d = OCC_EMPTY;
                    end
                end else if (enq) begin
                    load_skid = 1'b1;
                    occ_d     = OCC_TWO;
                end
            end
            OCC_TWO: begin
                if (done) begin
                    shift_skid = 1'b1;
                    occ_d      = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // Head and skid address/data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_addr <= '0;
            head_data <= '0;
            skid_addr <= '0;
            skid_data <= '0;
        end else begin
            if (load_head) begin
                head_addr <= in_rd;
                head_data <= result;
            end else if (shift_skid) begin
                head_addr <= skid_addr;
                head_data <= skid_data;
            end
            if (load_skid) begin
                skid_addr <= in_rd;
                skid_data <= result;
            end
        end
    end

    // Retired-instruction counter, one per accepted beat, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stage_wb_buffered.sv
// Bench for stage_wb_buffered: directed beats, a queue-based reference model
// compared every cycle, and literal spot checks of key values.
module tb_stage_wb_buffered;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_regwrite;
    logic [1:0]        in_result_src;
    logic [DATA_W-1:0] in_alu, in_mem, in_link, in_imm;
    logic              in_load_narrow;
    logic              in_load_sx;
    logic [ADDR_W-1:0] in_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              fwd0_valid, fwd1_valid;
    logic [ADDR_W-1:0] fwd0_addr, fwd1_addr;
    logic [DATA_W-1:0] fwd0_data, fwd1_data;
    logic [CNT_W-1:0]  retire_count;

    int checks   = 0;
    int failures = 0;

    stage_wb_buffered #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_regwrite   (in_regwrite),
        .in_result_src (in_result_src),
        .in_alu        (in_alu),
        .in_mem        (in_mem),
        .in_link       (in_link),
        .in_imm        (in_imm),
        .in_load_narrow(in_load_narrow),
        .in_load_sx    (in_load_sx),
        .in_rd         (in_rd),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .fwd0_valid    (fwd0_valid),
        .fwd0_addr     (fwd0_addr),
        .fwd0_data     (fwd0_data),
        .fwd1_valid    (fwd1_valid),
        .fwd1_addr     (fwd1_addr),
        .fwd1_data     (fwd1_data),
        .retire_count  (retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes in acceptance order plus a retire count.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t q[$];
    int  m_cnt  = 0;
    bit  m_live = 0;

    function automatic logic [DATA_W-1:0] model_result();
        int lo, r;
        case (in_result_src)
            2'd0: r = int'(in_alu);
            2'd1: begin
                if (in_load_narrow) begin
                    lo = int'(in_mem) % (1 << (DATA_W/2));
                    if (in_load_sx && lo >= (1 << (DATA_W/2 - 1)))
                        r = lo + (1 << DATA_W) - (1 << (DATA_W/2));
                    else
                        r = lo;
                end else begin
                    r = int'(in_mem);
                end
            end
            2'd2: r = int'(in_link);
            default: r = int'(in_imm);
        endcase
        return DATA_W'(r);
    endfunction

    // Compare on the falling edge, then advance the model with the inputs the
    // DUT will sample at the next rising edge.
    always @(negedge clk) begin
        wr_t e;
        bit  acc, fin;
        if (m_live) begin
            chk("wr_en", 32'(wr_en), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("fwd0_valid", 32'(fwd0_valid), 32'(q.size() != 0));
            chk("fwd1_valid", 32'(fwd1_valid), 32'(q.size() == 2));
            chk("retire_count", 32'(retire_count), 32'(m_cnt % (1 << CNT_W)));
            if (q.size() != 0) begin
                chk("wr_addr", 32'(wr_addr), 32'(q[0].addr));
                chk("wr_data", 32'(wr_data), 32'(q[0].data));
                chk("fwd0_addr", 32'(fwd0_addr), 32'(q[0].addr));
                chk("fwd0_data", 32'(fwd0_data), 32'(q[0].data));
            end
            if (q.size() == 2) begin
                chk("fwd1_addr", 32'(fwd1_addr), 32'(q[1].addr));
                chk("fwd1_data", 32'(fwd1_data), 32'(q[1].data));
            end
        end
        if (reset) begin
            q.delete();
            m_cnt  = 0;
            m_live = 1;
        end else if (m_live) begin
            fin = (q.size() != 0) && wr_ready;
            acc = in_valid && (q.size() < 2) && !flush;
            if (fin) void'(q.pop_front());
            if (acc) begin
                m_cnt++;
                if (in_regwrite) begin
                    e.addr = in_rd;
                    e.data = model_result();
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid       = 1'b0;
        flush          = 1'b0;
        in_regwrite    = 1'b0;
        in_result_src  = 2'd0;
        in_alu         = 8'hE1;
        in_mem         = 8'hE2;
        in_link        = 8'hE3;
        in_imm         = 8'hE4;
        in_load_narrow = 1'b0;
        in_load_sx     = 1'b0;
        in_rd          = '0;
    endtask

    task automatic beat(input logic rw, input logic [1:0] src, input logic [7:0] val,
                        input logic nar, input logic sx, input logic [2:0] rd, input logic fl);
        idle();
        in_valid       = 1'b1;
        in_regwrite    = rw;
        in_result_src  = src;
        in_load_narrow = nar;
        in_load_sx     = sx;
        in_rd          = rd;
        flush          = fl;
        case (src)
            2'd0: in_alu  = val;
            2'd1: in_mem  = val;
            2'd2: in_link = val;
            default: in_imm = val;
        endcase
    endtask

    initial begin
        idle();
        reset    = 1'b1;
        wr_ready = 1'b1;
        repeat (3) step();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_fwd1_data", 32'(fwd1_data), 32'd0);
        chk("rst_count", 32'(retire_count), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ALU beats.
        beat(1, 2'd0, 8'h11, 0, 0, 3'd1, 0);
        step();
        chk("b2b_first", 32'({wr_addr, wr_data}), 32'({3'd1, 8'h11}));
        beat(1, 2'd0, 8'h22, 0, 0, 3'd2, 0);
        step();
        chk("b2b_second", 32'({wr_addr, wr_data}), 32'({3'd2, 8'h22}));
        idle();
        step();
        chk("b2b_count", 32'(retire_count), 32'd2);

        // Narrow and full loads, then an immediate.
        beat(1, 2'd1, 8'h3C, 1, 1, 3'd3, 0);
        step();
        chk("narrow_sx", 32'(wr_data), 32'hFC);
        beat(1, 2'd1, 8'h3C, 1, 0, 3'd3, 0);
        step();
        chk("narrow_zx", 32'(wr_data), 32'h0C);
        beat(1, 2'd1, 8'h8A, 0, 1, 3'd3, 0);
        step();
        chk("full_load", 32'(wr_data), 32'h8A);
        beat(1, 2'd3, 8'h96, 0, 1, 3'd5, 0);
        step();
        chk("imm_verbatim", 32'(wr_data), 32'h96);
        idle();
        step();

        // Stall with three beats presented.
        wr_ready = 1'b0;
        beat(1, 2'd0, 8'hA4, 0, 0, 3'd4, 0);
        step();
        beat(1, 2'd0, 8'hB5, 0, 0, 3'd5, 0);
        step();
        chk("stall_fwd0", 32'({fwd0_valid, fwd0_addr, fwd0_data}), 32'({1'b1, 3'd4, 8'hA4}));
        chk("stall_fwd1", 32'({fwd1_valid, fwd1_addr, fwd1_data}), 32'({1'b1, 3'd5, 8'hB5}));
        chk("stall_ready", 32'(in_ready), 32'd0);
        beat(1, 2'd0, 8'hC6, 0, 0, 3'd6, 0);
        step();
        chk("stall_hold", 32'({wr_addr, wr_data, fwd1_data}), 32'({3'd4, 8'hA4, 8'hB5}));
        wr_ready = 1'b1;
        step();
        chk("drain_b", 32'({wr_addr, wr_data}), 32'({3'd5, 8'hB5}));
        step();
        chk("drain_c", 32'({wr_addr, wr_data}), 32'({3'd6, 8'hC6}));
        idle();
        step();
        chk("drain_empty", 32'(wr_en), 32'd0);
        chk("drain_count", 32'(retire_count), 32'd9);

        // Flushed beat while head pending.
        wr_ready = 1'b0;
        beat(1, 2'd0, 8'h77, 0, 0, 3'd7, 0);
        step();
        beat(1, 2'd0, 8'h99, 0, 0, 3'd1, 1);
        step();
        chk("flush_no_skid", 32'(fwd1_valid), 32'd0);
        chk("flush_count", 32'(retire_count), 32'd10);
        idle();
        wr_ready = 1'b1;
        step();
        chk("flush_head_done", 32'(wr_en), 32'd0);

        // Non-writing beat between two writes; last one uses the link source.
        beat(1, 2'd0, 8'h12, 0, 0, 3'd2, 0);
        step();
        beat(0, 2'd0, 8'h33, 0, 0, 3'd3, 0);
        step();
        chk("nowrite_no_en", 32'(wr_en), 32'd0);
        beat(1, 2'd2, 8'h14, 0, 0, 3'd4, 0);
        step();
        chk("link_write", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 3'd4, 8'h14}));
        idle();
        step();
        chk("nowrite_count", 32'(retire_count), 32'd13);

        // Counter wrap at CNT_W=4.
        for (int i = 0; i < 2; i++) begin
            beat(0, 2'd0, 8'h00, 0, 0, 3'd0, 0);
            step();
        end
        idle();
        step();
        chk("count_15", 32'(retire_count), 32'd15);
        beat(0, 2'd0, 8'h00, 0, 0, 3'd0, 0);
        step();
        chk("count_wrap", 32'(retire_count), 32'd0);

        // Reset with both entries full.
        wr_ready = 1'b0;
        beat(1, 2'd0, 8'h5D, 0, 0, 3'd5, 0);
        step();
        beat(1, 2'd0, 8'h6E, 0, 0, 3'd6, 0);
        step();
        chk("full_before_rst", 32'(fwd1_valid), 32'd1);
        idle();
        reset    = 1'b1;
        wr_ready = 1'b1;
        step();
        chk("midrst_state", 32'({wr_en, fwd0_valid, fwd1_valid}), 32'd0);
        chk("midrst_count", 32'(retire_count), 32'd0);
        reset = 1'b0;
        beat(1, 2'd0, 8'h42, 0, 0, 3'd3, 0);
        step();
        chk("post_rst_write", 32'({wr_addr, wr_data}), 32'({3'd3, 8'h42}));
        idle();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
